// File: rtl/serial_uart_pkg.sv
// Shared definitions for the serial UART blocks: parity modes, receiver
// FSM state encoding and small elaboration-time helper functions.
package serial_uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_PUSH   = 3'd5;

  // Number of bits needed to hold values 0..value-1 (never less than 1).
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

  // System clocks per serial bit period.
  function automatic int bit_ticks(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/serial_sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is presented on rdata while
// valid is high, and a pop simply advances to the next entry.
module serial_sync_fifo
  import serial_uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   valid,
  output logic                   full,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & valid;
  // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign rdata   = valid ? mem[rd_ptr] : '0;

  // Storage array; contents are only meaningful where count says so, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, per-character parity and
// framing tags, a show-ahead receive FIFO and CTS flow control.
module serial_uart_rx_fifo
  import serial_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 2,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int CTS_MARGIN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_perr,
  output logic                 m_ferr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 cts,
  output logic                 overflow,
  input  logic                 ovf_clr,
  output logic                 brk
);

  localparam int BIT_TICKS = bit_ticks(CLK_FREQ, BAUD_RATE);
  localparam int MID       = BIT_TICKS / 2;
  localparam int TW        = clog2(BIT_TICKS);
  localparam int CW        = clog2(FIFO_DEPTH) + 1;
  localparam int EW        = DATA_BITS + 2;

  localparam logic [TW-1:0] T_EARLY = TW'(MID - 1);
  localparam logic [TW-1:0] T_MID   = TW'(MID);
  localparam logic [TW-1:0] T_LATE  = TW'(MID + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(BIT_TICKS - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] CTS_LIMIT = CW'(FIFO_DEPTH - CTS_MARGIN);

  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic [2:0]           state;
  logic [TW-1:0]        tick;
  logic [3:0]           bit_cnt;
  logic                 s_early;
  logic                 s_mid;
  logic                 vote;
  logic                 sample_now;
  logic                 tick_last;
  logic [DATA_BITS-1:0] data_sr;
  logic                 par_bit;
  logic                 ferr_acc;
  logic                 perr_calc;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic [CW-1:0]        fifo_count;
  logic [EW-1:0]        fifo_rdata;

  // Synchroniser and edge history; all three reset low so that a line held
  // low across reset release never looks like a fresh start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign tick_last  = (tick == T_LAST);
  assign sample_now = (tick == T_LATE);
  assign vote       = (s_early & s_mid) | (s_early & rx_sync) | (s_mid & rx_sync);

  // Receiver FSM with bit-period tick counter, bit counter and data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tick     <= '0;
      bit_cnt  <= '0;
      s_early  <= 1'b0;
      s_mid    <= 1'b0;
      data_sr  <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      tick <= tick_last ? '0 : tick + 1'b1;
      if (tick == T_EARLY) s_early <= rx_sync;
      if (tick == T_MID)   s_mid   <= rx_sync;
      case (state)
        ST_IDLE: begin
          tick <= '0;
          if (rx_prev && !rx_sync) begin
            state    <= ST_START;
            bit_cnt  <= '0;
            ferr_acc <= 1'b0;
          end
        end
        ST_START: begin
          if (sample_now && vote) begin
            state <= ST_IDLE;
            tick  <= '0;
          end else if (tick_last) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (sample_now) data_sr <= {vote, data_sr[DATA_BITS-1:1]};
          if (tick_last) begin
            if (bit_cnt == DATA_LAST) begin
              state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (sample_now) par_bit <= vote;
          if (tick_last) begin
            state   <= ST_STOP;
            bit_cnt <= '0;
          end
        end
        ST_STOP: begin
          if (sample_now && !vote) ferr_acc <= 1'b1;
          if (sample_now && bit_cnt == STOP_LAST) begin
            state   <= ST_PUSH;
            tick    <= '0;
            bit_cnt <= '0;
          end else if (tick_last) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_PUSH: begin
          state <= ST_IDLE;
          tick  <= '0;
        end
        default: begin
          state <= ST_IDLE;
          tick  <= '0;
        end
      endcase
    end
  end

  // Parity check result for the character just assembled.
  always_comb begin
    perr_calc = 1'b0;
    if (PARITY == PAR_EVEN)     perr_calc = ^{data_sr, par_bit};
    else if (PARITY == PAR_ODD) perr_calc = ~^{data_sr, par_bit};
  end

  assign push = (state == ST_PUSH);
  assign pop  = m_valid & m_ready;
  assign brk  = push && (data_sr == '0) && ferr_acc;

  serial_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({ferr_acc, perr_calc, data_sr}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (m_valid),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign {m_ferr, m_perr, m_data} = fifo_rdata;

  // Sticky overflow (a new drop beats a clear) and registered CTS from free space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      cts      <= 1'b0;
    end else begin
      if (push && fifo_full && !pop) overflow <= 1'b1;
      else if (ovf_clr)              overflow <= 1'b0;
      cts <= (fifo_count <= CTS_LIMIT);
    end
  end

endmodule

// File: tb/tb_serial_uart_rx_fifo.sv
// Bench for serial_uart_rx_fifo: two instances (8E1 and 7O2) on a short bit
// period, random and directed characters, scoreboard checked on every pop.
module tb_serial_uart_rx_fifo;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int BT       = CLK_FREQ / BAUD;
  localparam int DEPTH    = 16;
  localparam int MARGIN   = 4;

  logic       clk;
  logic       rst_n;
  logic       rx_a, rx_b;
  logic       m_ready_a, m_ready_b;
  logic       ovf_clr_a, ovf_clr_b;
  logic [7:0] m_data_a;
  logic [6:0] m_data_b;
  logic       m_perr_a, m_ferr_a, m_valid_a, cts_a, overflow_a, brk_a;
  logic       m_perr_b, m_ferr_b, m_valid_b, cts_b, overflow_b, brk_b;

  int          vectors;
  int          miscompares;
  logic [10:0] exp_a[$];
  logic [10:0] exp_b[$];
  int          brk_exp_a, brk_exp_b, brk_seen_a, brk_seen_b;
  logic        ovf_exp_a;

  logic [8:0] frame [8] = '{9'h0FF, 9'h0FF, 9'h000, 9'h002, 9'h002, 9'h003, 9'h0EE, 9'h0EE};

  serial_uart_rx_fifo #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
    .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .CTS_MARGIN(MARGIN)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .m_data(m_data_a), .m_perr(m_perr_a),
    .m_ferr(m_ferr_a), .m_valid(m_valid_a), .m_ready(m_ready_a), .cts(cts_a),
    .overflow(overflow_a), .ovf_clr(ovf_clr_a), .brk(brk_a)
  );

  serial_uart_rx_fifo #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1),
    .STOP_BITS(2), .FIFO_DEPTH(DEPTH), .CTS_MARGIN(MARGIN)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .m_data(m_data_b), .m_perr(m_perr_b),
    .m_ferr(m_ferr_b), .m_valid(m_valid_b), .m_ready(m_ready_b), .cts(cts_b),
    .overflow(overflow_b), .ovf_clr(ovf_clr_b), .brk(brk_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
    end
  endtask

  // Pop the oldest expected entry for an instance and compare with the FIFO head.
  task automatic scoreboardPop(input int inst, input logic [10:0] act);
    logic [10:0] exp;
    vectors++;
    if ((inst == 0 && exp_a.size() == 0) || (inst == 1 && exp_b.size() == 0)) begin
      miscompares++;
      $display("[TB] FAIL pop_%0d_unexpected: actual %03h, required no entry", inst, act);
    end else begin
      exp = (inst == 0) ? exp_a.pop_front() : exp_b.pop_front();
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL pop_%0d_entry: actual {ferr,perr,data}=%03h, required %03h", inst, act, exp);
      end
    end
  endtask

  // Monitor: every accepted pop is checked; break pulses are counted per cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid_a && m_ready_a) scoreboardPop(0, {m_ferr_a, m_perr_a, 1'b0, m_data_a});
      if (m_valid_b && m_ready_b) scoreboardPop(1, {m_ferr_b, m_perr_b, 2'b00, m_data_b});
    end
    if (brk_a) brk_seen_a++;
    if (brk_b) brk_seen_b++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setRx(input int inst, input logic v);
    if (inst == 0) rx_a = v;
    else           rx_b = v;
  endtask

  // Parity bit a well-behaved sender would transmit for this instance.
  function automatic logic goodPar(input int inst, input logic [8:0] d);
    logic [8:0] m;
    m = (inst == 0) ? (d & 9'h0FF) : (d & 9'h07F);
    return (inst == 0) ? (^m) : ~(^m);
  endfunction

  // Send one character; the expected FIFO entry is queued as it is issued.
  task automatic applyStimulus(input int inst, input logic [8:0] data, input logic par,
                               input logic [1:0] stop_vals);
    int          db, sb;
    logic [8:0]  d;
    logic        ferr, perr;
    logic [10:0] entry;
    db   = (inst == 0) ? 8 : 7;
    sb   = (inst == 0) ? 1 : 2;
    d    = (inst == 0) ? (data & 9'h0FF) : (data & 9'h07F);
    ferr = 1'b0;
    for (int s = 0; s < sb; s++) if (!stop_vals[s]) ferr = 1'b1;
    if (inst == 0) perr = ((^{d, par}) != 1'b0);
    else           perr = ((^{d, par}) != 1'b1);
    entry = {ferr, perr, d};
    if (inst == 0) begin
      if (exp_a.size() < DEPTH) exp_a.push_back(entry);
      else                      ovf_exp_a = 1'b1;
      if (d == 0 && ferr) brk_exp_a++;
    end else begin
      if (exp_b.size() < DEPTH) exp_b.push_back(entry);
      if (d == 0 && ferr) brk_exp_b++;
    end
    setRx(inst, 1'b0);
    idle(BT);
    for (int i = 0; i < db; i++) begin
      setRx(inst, d[i]);
      idle(BT);
    end
    setRx(inst, par);
    idle(BT);
    for (int s = 0; s < sb; s++) begin
      setRx(inst, stop_vals[s]);
      idle(BT);
    end
    setRx(inst, 1'b1);
  endtask

  initial begin
    logic [8:0] d;
    logic       p;
    logic [1:0] st;
    vectors = 0; miscompares = 0;
    brk_exp_a = 0; brk_exp_b = 0; brk_seen_a = 0; brk_seen_b = 0;
    ovf_exp_a = 1'b0;
    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    m_ready_a = 1'b0; m_ready_b = 1'b0; ovf_clr_a = 1'b0; ovf_clr_b = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rst_valid", m_valid_a, 0);
    checkOutput("rst_data", m_data_a, 0);
    checkOutput("rst_perr", m_perr_a, 0);
    checkOutput("rst_ferr", m_ferr_a, 0);
    checkOutput("rst_cts", cts_a, 0);
    checkOutput("rst_overflow", overflow_a, 0);
    checkOutput("rst_brk", brk_a, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("cts_after_release_a", cts_a, 1);
    checkOutput("cts_after_release_b", cts_b, 1);
    idle(4);

    // Directed characters on the 8E1 instance.
    m_ready_a = 1'b1;
    applyStimulus(0, 9'h0FF, 1'b0, 2'b11);             idle(2 * BT);
    applyStimulus(0, 9'h002, 1'b0, 2'b11);             idle(2 * BT);
    applyStimulus(0, 9'h003, goodPar(0, 9'h003), 2'b00); idle(2 * BT);
    applyStimulus(0, 9'h000, goodPar(0, 9'h000), 2'b00); idle(2 * BT);

    // Short low glitch must not produce a character.
    rx_a = 1'b0; idle(4); rx_a = 1'b1; idle(3 * BT);
    checkOutput("glitch_valid", m_valid_a, 0);

    // Back-to-back frame at full rate.
    for (int i = 0; i < 8; i++) applyStimulus(0, frame[i], goodPar(0, frame[i]), 2'b11);
    idle(2 * BT);

    // Random characters with occasional parity and framing faults.
    for (int i = 0; i < 12; i++) begin
      d  = 9'($urandom_range(0, 255));
      p  = goodPar(0, d) ^ ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'b11;
      applyStimulus(0, d, p, st);
      if (st != 2'b11)               idle(BT);
      else if ($urandom_range(0, 1)) idle(BT);
    end
    idle(2 * BT);

    // Fill past capacity with the consumer stalled.
    m_ready_a = 1'b0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(0, frame[i % 8], goodPar(0, frame[i % 8]), 2'b11);
      idle(4);
      checkOutput("fill_cts", cts_a, ((DEPTH - exp_a.size()) >= MARGIN) ? 1 : 0);
      checkOutput("fill_overflow", overflow_a, ovf_exp_a);
      idle(BT - 4);
    end
    ovf_clr_a = 1'b1; idle(1); ovf_clr_a = 1'b0; ovf_exp_a = 1'b0;
    @(negedge clk);
    checkOutput("ovf_clear", overflow_a, ovf_exp_a);
    m_ready_a = 1'b1; idle(40);
    checkOutput("drain_valid_a", m_valid_a, 0);
    checkOutput("drain_cts_a", cts_a, 1);

    // 7O2 instance: good, bad parity, second stop low, break, then random.
    m_ready_b = 1'b1;
    applyStimulus(1, 9'h055, goodPar(1, 9'h055), 2'b11);  idle(BT);
    applyStimulus(1, 9'h02A, ~goodPar(1, 9'h02A), 2'b11); idle(BT);
    applyStimulus(1, 9'h011, goodPar(1, 9'h011), 2'b01);  idle(BT);
    applyStimulus(1, 9'h000, goodPar(1, 9'h000), 2'b00);  idle(BT);
    for (int i = 0; i < 8; i++) begin
      d  = 9'($urandom_range(0, 127));
      p  = goodPar(1, d) ^ ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      applyStimulus(1, d, p, st);
      if (st != 2'b11) idle(BT);
    end
    idle(2 * BT);

    // Reset in the middle of a character: FIFO flushed, nothing pushed after.
    m_ready_b = 1'b0;
    applyStimulus(1, 9'h07F, goodPar(1, 9'h07F), 2'b11);
    applyStimulus(1, 9'h001, goodPar(1, 9'h001), 2'b11);
    idle(BT);
    checkOutput("pre_reset_valid_b", m_valid_b, (exp_b.size() != 0) ? 1 : 0);
    rx_b = 1'b0; idle(3 * BT);
    rst_n = 1'b0;
    exp_a.delete(); exp_b.delete(); ovf_exp_a = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(4 * BT); rx_b = 1'b1; idle(12 * BT);
    checkOutput("mid_reset_valid_b", m_valid_b, 0);
    m_ready_b = 1'b1;
    applyStimulus(1, 9'h03C, goodPar(1, 9'h03C), 2'b11);
    idle(2 * BT);

    checkOutput("brk_count_a", brk_seen_a, brk_exp_a);
    checkOutput("brk_count_b", brk_seen_b, brk_exp_b);
    checkOutput("missing_entries_a", exp_a.size(), 0);
    checkOutput("missing_entries_b", exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
